// File: rtl/if_stage.sv
// Instruction fetch stage: BOOT/FETCH/HOLD sequencer with one-entry skid buffer.
// Optional macro IF_SQUASH_NOP_EN turns words fetched while JUMPEN is high into nops.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] next_pc,
    output logic        JUMPEN
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_npc_q, buf_npc_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic        redir_eff;
    logic        squash;

    assign pc_plus4  = pc_q + 32'd4;
    assign redir_eff = redirect && (state_q != BOOT);
    assign JUMPEN    = (cnt_q != 2'd0);
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign next_pc   = npc_q;

`ifdef IF_SQUASH_NOP_EN
    assign squash = JUMPEN;
`else
    assign squash = 1'b0;
`endif

    // Next-state, pc, output and buffer selection for the fetch sequencer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        npc_d       = npc_q;
        buf_instr_d = buf_instr_q;
        buf_npc_d   = buf_npc_q;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redir_eff) begin
                    pc_d        = {redirect_pc[31:2], 2'b00};
                    instr_d     = 32'd0;
                    buf_instr_d = 32'd0;
                    buf_npc_d   = 32'd0;
                end else if (imem_ready && !stall) begin
                    instr_d = squash ? 32'd0 : imem_rdata;
                    npc_d   = pc_plus4;
                    pc_d    = pc_plus4;
                end else if (imem_ready) begin
                    buf_instr_d = imem_rdata;
                    buf_npc_d   = pc_plus4;
                    state_d     = HOLD;
                end else if (!stall) begin
                    instr_d = 32'd0;
                end
            end
            HOLD: begin
                if (redir_eff) begin
                    pc_d        = {redirect_pc[31:2], 2'b00};
                    instr_d     = 32'd0;
                    buf_instr_d = 32'd0;
                    buf_npc_d   = 32'd0;
                    state_d     = FETCH;
                end else if (!stall) begin
                    instr_d = squash ? 32'd0 : buf_instr_q;
                    npc_d   = buf_npc_q;
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Squash window: reload on redirect, count down only on unstalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (redir_eff) begin
            cnt_d = 2'd3;
        end else if (!stall && cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // State registers; reset drops any outstanding access and buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            npc_q       <= RESET_PC;
            buf_instr_q <= 32'd0;
            buf_npc_q   <= 32'd0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            npc_q       <= npc_d;
            buf_instr_q <= buf_instr_d;
            buf_npc_q   <= buf_npc_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns ~address as the word.
// Expected squashed words follow IF_SQUASH_NOP_EN when it is defined.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        JUMPEN;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .next_pc     (next_pc),
        .JUMPEN      (JUMPEN)
    );

    assign imem_rdata = ~imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sq(input logic [31:0] w);
`ifdef IF_SQUASH_NOP_EN
        return 32'd0;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b1;
        #3;
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_npc",   next_pc, 32'd0);
        chk("rst_jump",  {31'd0, JUMPEN}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);

        tick();
        chk("f0_req",   {31'd0, imem_req}, 32'd1);
        chk("f0_addr",  imem_addr, 32'd0);
        chk("f0_instr", instr, 32'd0);
        tick();
        chk("f1_instr", instr, 32'hFFFF_FFFF);
        chk("f1_npc",   next_pc, 32'd4);
        chk("f1_addr",  imem_addr, 32'd4);
        tick();
        chk("f2_instr", instr, 32'hFFFF_FFFB);
        chk("f2_npc",   next_pc, 32'd8);
        chk("f2_addr",  imem_addr, 32'd8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req",   {31'd0, imem_req}, 32'd0);
            chk("hold_instr", instr, 32'hFFFF_FFFB);
            chk("hold_npc",   next_pc, 32'd8);
            chk("hold_addr",  imem_addr, 32'd8);
        end
        stall = 1'b0;
        tick();
        chk("unh_instr", instr, 32'hFFFF_FFF7);
        chk("unh_npc",   next_pc, 32'd12);
        chk("unh_addr",  imem_addr, 32'd12);
        chk("unh_req",   {31'd0, imem_req}, 32'd1);

        stall = 1'b1;
        tick();
        chk("h2_req", {31'd0, imem_req}, 32'd0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        chk("rd1_addr",  imem_addr, 32'h0000_0100);
        chk("rd1_instr", instr, 32'd0);
        chk("rd1_jump",  {31'd0, JUMPEN}, 32'd1);
        chk("rd1_req",   {31'd0, imem_req}, 32'd1);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        chk("sq1_instr", instr, sq(32'hFFFF_FEFF));
        chk("sq1_npc",   next_pc, 32'h0000_0104);
        chk("sq1_addr",  imem_addr, 32'h0000_0104);
        chk("sq1_jump",  {31'd0, JUMPEN}, 32'd1);
        tick();
        chk("sq2_instr", instr, sq(32'hFFFF_FEFB));
        chk("sq2_npc",   next_pc, 32'h0000_0108);
        chk("sq2_jump",  {31'd0, JUMPEN}, 32'd1);

        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        chk("rd2_addr",  imem_addr, 32'h0000_0040);
        chk("rd2_instr", instr, 32'd0);
        chk("rd2_jump",  {31'd0, JUMPEN}, 32'd1);
        redirect   = 1'b0;
        stall      = 1'b1;
        imem_ready = 1'b0;
        tick();
        chk("st_addr",  imem_addr, 32'h0000_0040);
        chk("st_instr", instr, 32'd0);
        chk("st_npc",   next_pc, 32'h0000_0108);
        chk("st_jump",  {31'd0, JUMPEN}, 32'd1);
        chk("st_req",   {31'd0, imem_req}, 32'd1);
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bub_instr", instr, 32'd0);
            chk("bub_addr",  imem_addr, 32'h0000_0040);
            chk("bub_npc",   next_pc, 32'h0000_0108);
            chk("bub_jump",  {31'd0, JUMPEN}, 32'd1);
        end
        imem_ready = 1'b1;
        tick();
        chk("w40_instr", instr, sq(32'hFFFF_FFBF));
        chk("w40_npc",   next_pc, 32'h0000_0044);
        chk("w40_addr",  imem_addr, 32'h0000_0044);
        chk("w40_jump",  {31'd0, JUMPEN}, 32'd0);

        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr_jump", {31'd0, JUMPEN}, 32'd1);
        redirect = 1'b0;
        tick();
        chk("wrap_instr", instr, sq(32'h0000_0003));
        chk("wrap_npc",   next_pc, 32'd0);
        chk("wrap_addr",  imem_addr, 32'd0);
        tick();
        chk("z_instr", instr, sq(32'hFFFF_FFFF));
        chk("z_npc",   next_pc, 32'd4);
        chk("z_addr",  imem_addr, 32'd4);
        stall = 1'b1;
        tick();
        chk("h3_req",  {31'd0, imem_req}, 32'd0);
        chk("h3_jump", {31'd0, JUMPEN}, 32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_addr",  imem_addr, 32'd0);
        chk("ar_instr", instr, 32'd0);
        chk("ar_npc",   next_pc, 32'd0);
        chk("ar_jump",  {31'd0, JUMPEN}, 32'd0);
        chk("ar_req",   {31'd0, imem_req}, 32'd0);
        tick();
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        rst_n       = 1'b1;
        tick();
        chk("bi_addr",  imem_addr, 32'd0);
        chk("bi_jump",  {31'd0, JUMPEN}, 32'd0);
        chk("bi_instr", instr, 32'd0);
        chk("bi_req",   {31'd0, imem_req}, 32'd1);
        redirect = 1'b0;
        tick();
        chk("pr_instr", instr, 32'hFFFF_FFFF);
        chk("pr_npc",   next_pc, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port stall  input  1  decode cannot accept; hold fetch outputs.
REQ-004 SHALL have port redirect  input  1  taken branch/jump/jr from a later stage.
REQ-005 SHALL have port redirect_pc  input  32  redirect target, byte address.
REQ-006 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-007 SHALL have port imem_addr  output  32  read address, always equal to internal pc.
REQ-008 SHALL have port imem_ready  input  1  imem_rdata valid this cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port instr  output  32  registered instruction to decode; 0 is a nop bubble.
REQ-011 SHALL have port next_pc  output  32  registered fetch address + 4 of instr.
REQ-012 SHALL have port JUMPEN  output  1  high while the squash counter is nonzero.
REQ-013 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.

Function
REQ-014 SHALL implement states BOOT, FETCH, HOLD.
REQ-015 BOOT SHALL last exactly one cycle after rst_n deasserts, imem_req=0, then go to FETCH.
REQ-016 FETCH SHALL drive imem_req=1 and imem_addr=pc.
REQ-017 FETCH, imem_ready=1, stall=0: instr<=imem_rdata, next_pc<=pc+4, pc<=pc+4, stay FETCH.
REQ-018 FETCH, imem_ready=1, stall=1: capture imem_rdata and pc+4 in a one-entry buffer, instr/next_pc unchanged, go HOLD.
REQ-019 FETCH, imem_ready=0, stall=0: instr<=0 (bubble), next_pc unchanged, pc unchanged.
REQ-020 FETCH, imem_ready=0, stall=1: all outputs and pc unchanged.
REQ-021 HOLD SHALL drive imem_req=0; while stall=1 hold everything; on stall=0 load instr/next_pc from buffer, pc<=pc+4, go FETCH.
REQ-022 redirect=1 in FETCH or HOLD SHALL, regardless of stall or imem_ready: pc<={redirect_pc[31:2],2'b00}, instr<=0, discard buffer and any returning word, go FETCH.
REQ-023 redirect during BOOT SHALL be ignored.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 Squash counter (2 bits): load 3 on redirect; otherwise decrement by 1 on each cycle with stall=0 while nonzero; hold when stall=1.
REQ-026 Redirect while counter nonzero SHALL reload 3.
REQ-027 JUMPEN SHALL be combinational from the counter (counter != 0), no extra latency.
REQ-028 Latency: imem_ready sampled with stall=0 -> instr valid at the next rising edge.

Reset
REQ-029 rst_n=0 SHALL immediately force state=BOOT, pc=RESET_PC, instr=0, next_pc=RESET_PC, counter=0, buffer empty.
REQ-030 Reset asserted mid-fetch or in HOLD SHALL discard the outstanding access; no output retains pre-reset data.

Configuration
REQ-031 Macro IF_SQUASH_NOP_EN defined: while counter nonzero, any word loaded into instr SHALL be replaced by 0 (next_pc still updated).
REQ-032 Macro IF_SQUASH_NOP_EN undefined: instr SHALL carry fetched words unmodified; squashing relies on JUMPEN alone.

Verification
REQ-033 Reset release, imem_ready=1 constant, RESET_PC=0 -> imem_addr 0,4,8 on consecutive FETCH cycles; instr follows one cycle later, next_pc=4,8,12.
REQ-034 stall=1 for 3 cycles when imem_ready=1 at pc=8 -> HOLD entered, imem_req=0, instr unchanged; stall drop -> instr=word@8, next_pc=12, imem_addr=12.
REQ-035 redirect=1 with redirect_pc=32'h0000_0103 during stall in HOLD -> next cycle imem_addr=32'h100, instr=0, buffer dropped, JUMPEN=1 for 3 unstalled cycles.
REQ-036 Second redirect when counter=1 -> counter reloads 3, JUMPEN high 3 further unstalled cycles.
REQ-037 imem_ready=0 for 2 cycles at pc=0x40 -> two instr=0 bubbles, imem_addr held at 0x40; then word@0x40 delivered with next_pc=0x44.
REQ-038 pc=32'hFFFF_FFFC fetch with ready -> next_pc=0, imem_addr=0; with IF_SQUASH_NOP_EN, fetches during JUMPEN present instr=0.
